// File: rtl/p3_execute.sv
// p3_execute: RV32IM execute stage, 1-cycle ALU plus a 32-step
// iterative mul/div that holds ID/EX via stall while it runs.
module p3_execute #(
  parameter int         XLEN        = 32,
  parameter logic [2:0] BUBBLE_TYPE = 3'd7,
  parameter bit         M_EXT       = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  input  logic [2:0]      type_in,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] PC,
  input  logic [6:0]      opcode,
  output logic            stall,
  output logic [XLEN-1:0] result_out,
  output logic [4:0]      rd_out,
  output logic            wb_en_out,
  output logic            valid_out,
  output logic [2:0]      type_out,
  output logic [XLEN-1:0] PC_out,
  output logic [6:0]      opcode_out
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE, BUSY_MUL, BUSY_DIV, DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] acc_hi, acc_lo;
  logic [XLEN-1:0] b_mag, a_orig, m_pc;
  logic [2:0]      m_f3;
  logic [4:0]      m_rd;
  logic [6:0]      m_op;
  logic            neg_q, neg_r, div0;

  logic is_m, sgn_a, sgn_b, wb_ok;
  logic [4:0] shamt;

  assign is_m  = M_EXT && (type_in == 3'd0)
              && (funct7 == 7'b0000001);
  assign sgn_a = rs1[XLEN-1]
              && !(funct3 inside {3'b011, 3'b101, 3'b111});
  assign sgn_b = rs2[XLEN-1]
              && (funct3 inside {3'b000, 3'b001, 3'b100, 3'b110});
  assign wb_ok = (rd != 5'd0) && (type_in != 3'd3)
              && (type_in != 3'd4);
  assign shamt = rs2[4:0];

  assign stall = !reset && ((state == IDLE && is_m)
              || state == BUSY_MUL || state == BUSY_DIV);

  logic [XLEN-1:0] alu;

  always_comb begin
    alu = rs1 + rs2;
    if (type_in <= 3'd1) begin
      unique case (funct3)
        3'b000: alu = (type_in == 3'd0 && funct7[5]) ?
                      rs1 - rs2 : rs1 + rs2;
        3'b001: alu = rs1 << shamt;
        3'b010: alu = {{(XLEN-1){1'b0}},
                       $signed(rs1) < $signed(rs2)};
        3'b011: alu = {{(XLEN-1){1'b0}}, rs1 < rs2};
        3'b100: alu = rs1 ^ rs2;
        3'b101: alu = funct7[5] ?
                      XLEN'($signed(rs1) >>> shamt) :
                      rs1 >> shamt;
        3'b110: alu = rs1 | rs2;
        3'b111: alu = rs1 & rs2;
      endcase
    end
  end

  // mul: acc_lo holds the shifting multiplier, acc_hi the partial sum.
  // div: acc_lo shifts dividend out and quotient in, acc_hi is remainder.
  logic [XLEN:0]   msum, dsh;
  logic [XLEN-1:0] ddiff;
  logic            dge;

  assign msum  = {1'b0, acc_hi}
               + (acc_lo[0] ? {1'b0, b_mag} : '0);
  assign dsh   = {acc_hi, acc_lo[XLEN-1]};
  assign dge   = dsh >= {1'b0, b_mag};
  assign ddiff = dsh[XLEN-1:0] - b_mag;

  logic [2*XLEN-1:0] prod, sprod;
  logic [XLEN-1:0]   m_res;

  assign prod  = {acc_hi, acc_lo};
  assign sprod = neg_q ? -prod : prod;

  always_comb begin
    m_res = sprod[2*XLEN-1:XLEN];
    if (!m_f3[2]) begin
      if (m_f3[1:0] == 2'b00) m_res = sprod[XLEN-1:0];
    end else if (div0) begin
      m_res = m_f3[1] ? a_orig : '1;
    end else if (m_f3[1]) begin
      m_res = neg_r ? -acc_hi : acc_hi;
    end else begin
      m_res = neg_q ? -acc_lo : acc_lo;
    end
  end

  always_ff @(posedge clock) begin
    unique case (state)
      IDLE: if (is_m) begin
        acc_hi <= '0;
        acc_lo <= sgn_a ? -rs1 : rs1;
        b_mag  <= sgn_b ? -rs2 : rs2;
        a_orig <= rs1;
        m_pc   <= PC;
        m_f3   <= funct3;
        m_rd   <= rd;
        m_op   <= opcode;
        neg_q  <= sgn_a ^ sgn_b;
        neg_r  <= sgn_a;
        div0   <= (rs2 == '0);
      end
      BUSY_MUL: begin
        acc_hi <= msum[XLEN:1];
        acc_lo <= {msum[0], acc_lo[XLEN-1:1]};
      end
      BUSY_DIV: begin
        acc_hi <= dge ? ddiff : dsh[XLEN-1:0];
        acc_lo <= {acc_lo[XLEN-2:0], dge};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      result_out <= '0;
      rd_out     <= '0;
      wb_en_out  <= 1'b0;
      valid_out  <= 1'b0;
      type_out   <= BUBBLE_TYPE;
      PC_out     <= '0;
      opcode_out <= '0;
    end else begin
      result_out <= '0;
      rd_out     <= '0;
      wb_en_out  <= 1'b0;
      valid_out  <= 1'b0;
      type_out   <= BUBBLE_TYPE;
      PC_out     <= '0;
      opcode_out <= '0;
      unique case (state)
        IDLE: begin
          if (is_m) begin
            state <= funct3[2] ? BUSY_DIV : BUSY_MUL;
            cnt   <= '0;
          end else if (type_in != BUBBLE_TYPE) begin
            result_out <= alu;
            rd_out     <= rd;
            wb_en_out  <= wb_ok;
            valid_out  <= 1'b1;
            type_out   <= type_in;
            PC_out     <= PC;
            opcode_out <= opcode;
          end
        end
        BUSY_MUL, BUSY_DIV: begin
          cnt <= cnt + CW'(1);
          if (&cnt) state <= DONE;
        end
        DONE: begin
          result_out <= m_res;
          rd_out     <= m_rd;
          wb_en_out  <= (m_rd != 5'd0);
          valid_out  <= 1'b1;
          type_out   <= 3'd0;
          PC_out     <= m_pc;
          opcode_out <= m_op;
          state      <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_p3_execute.sv
// tb_p3_execute: directed plus randomized checks of p3_execute
// against an arithmetic reference model.
module tb_p3_execute;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  funct7 = '0;
  logic [2:0]  funct3 = '0;
  logic [2:0]  type_in = 3'd7;
  logic [31:0] rs1 = '0, rs2 = '0, PC = '0;
  logic [4:0]  rd = '0;
  logic [6:0]  opcode = '0;
  logic        stall, wb_en_out, valid_out;
  logic [31:0] result_out, PC_out;
  logic [4:0]  rd_out;
  logic [2:0]  type_out;
  logic [6:0]  opcode_out;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  p3_execute dut (
    .clock(clock), .reset(reset),
    .funct7(funct7), .funct3(funct3), .type_in(type_in),
    .rs1(rs1), .rs2(rs2), .rd(rd), .PC(PC), .opcode(opcode),
    .stall(stall), .result_out(result_out), .rd_out(rd_out),
    .wb_en_out(wb_en_out), .valid_out(valid_out),
    .type_out(type_out), .PC_out(PC_out), .opcode_out(opcode_out)
  );

  function automatic logic [31:0] ref_alu(
    input logic [2:0] t, input logic [6:0] f7,
    input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    if (t >= 3'd2) return a + b;
    case (f3)
      3'd0: r = (t == 3'd0 && f7[5]) ? a - b : a + b;
      3'd1: r = a << b[4:0];
      3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: r = (a < b) ? 32'd1 : 32'd0;
      3'd4: r = a ^ b;
      3'd5: r = f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] ref_m(
    input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFFFFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 50));
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [2:0] t, input logic [6:0] f7,
                       input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] d);
    type_in = t; funct7 = f7; funct3 = f3;
    rs1 = a; rs2 = b; rd = d;
    PC = $urandom; opcode = 7'($urandom);
    #1;
  endtask

  task automatic base_op(input string tag, input logic [2:0] t,
                         input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d);
    logic [31:0] pc;
    logic [6:0] op;
    logic wb;
    drive(t, f7, f3, a, b, d);
    pc = PC; op = opcode;
    wb = (d != 0) && t != 3'd3 && t != 3'd4;
    chk({tag, " stall"}, 64'(stall), 64'd0);
    step();
    chk({tag, " result"}, 64'(result_out), 64'(ref_alu(t, f7, f3, a, b)));
    chk({tag, " ctl"}, 64'({valid_out, wb_en_out, type_out, rd_out}),
        64'({1'b1, wb, t, d}));
    chk({tag, " pc/op"}, 64'({PC_out, opcode_out}), 64'({pc, op}));
  endtask

  task automatic run_m(input string tag, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] d, input logic [31:0] exp,
                       input bit nxt_add);
    logic [31:0] pc, xa, xb;
    logic [6:0] op;
    logic [4:0] xd;
    int n, vc;
    drive(3'd0, 7'b0000001, f3, a, b, d);
    pc = PC; op = opcode;
    n = 0; vc = 0;
    while (stall && n < 40) begin
      n++;
      if (n > 1 && valid_out) vc++;
      step();
    end
    if (valid_out) vc++;
    chk({tag, " stall cycles"}, 64'(n), 64'd33);
    chk({tag, " early valid"}, 64'(vc), 64'd0);
    step();
    chk({tag, " result"}, 64'(result_out), 64'(exp));
    chk({tag, " ctl"}, 64'({valid_out, wb_en_out, type_out, rd_out}),
        64'({1'b1, d != 5'd0, 3'd0, d}));
    chk({tag, " pc/op"}, 64'({PC_out, opcode_out}), 64'({pc, op}));
    xa = $urandom; xb = $urandom; xd = 5'($urandom_range(1, 31));
    if (nxt_add) drive(3'd0, 7'd0, 3'd0, xa, xb, xd);
    else drive(3'd7, 7'd0, 3'd0, 32'd0, 32'd0, 5'd0);
    step();
    if (nxt_add)
      chk({tag, " next add"}, 64'({valid_out, result_out}),
          64'({1'b1, xa + xb}));
    else
      chk({tag, " single valid"}, 64'(valid_out), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vc;
    step(); step();
    chk("reset stall", 64'(stall), 64'd0);
    chk("reset result", 64'(result_out), 64'd0);
    chk("reset ctl", 64'({valid_out, wb_en_out, type_out, rd_out}),
        64'({1'b0, 1'b0, 3'd7, 5'd0}));
    chk("reset pc/op", 64'({PC_out, opcode_out}), 64'd0);
    reset = 1'b0;
    step();
    chk("bubble ctl", 64'({valid_out, wb_en_out, type_out}),
        64'({1'b0, 1'b0, 3'd7}));

    base_op("sub", 3'd0, 7'b0100000, 3'd0, 32'd5, 32'd7, 5'd3);
    chk("sub literal", 64'(result_out), 64'hFFFFFFFE);
    base_op("srai", 3'd1, 7'b0100000, 3'd5, 32'h80000000,
            32'h404, 5'd8);
    chk("srai literal", 64'(result_out), 64'hF8000000);
    base_op("store", 3'd3, 7'd0, 3'd2, 32'd100, 32'd8, 5'd5);
    base_op("load rd0", 3'd2, 7'd0, 3'd2, 32'd100, 32'hFFFFFFFC, 5'd0);

    run_m("mulh", 3'b001, 32'hFFFFFFFF, 32'd2, 5'd1, 32'hFFFFFFFF, 0);
    run_m("div by0", 3'b100, 32'd7, 32'd0, 5'd2, 32'hFFFFFFFF, 0);
    run_m("rem by0", 3'b110, 32'd7, 32'd0, 5'd2, 32'd7, 0);
    run_m("div ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd4,
          32'h80000000, 0);
    run_m("rem ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd4,
          32'd0, 0);
    run_m("remu", 3'b111, 32'd100, 32'd7, 5'd6, 32'd2, 0);
    run_m("divu rd0", 3'b101, 32'd100, 32'd7, 5'd0, 32'd14, 0);
    run_m("mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9,
          32'hFFFFFFFE, 0);
    run_m("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9,
          32'hFFFFFFFF, 0);
    run_m("mul+add", 3'b000, 32'd3, 32'd4, 5'd7, 32'd12, 1);

    drive(3'd0, 7'b0000001, 3'b000, 32'd1234, 32'd5678, 5'd9);
    chk("abort start stall", 64'(stall), 64'd1);
    repeat (11) step();
    chk("abort busy stall", 64'(stall), 64'd1);
    reset = 1'b1;
    #1;
    chk("abort reset-cycle stall", 64'(stall), 64'd0);
    step();
    reset = 1'b0;
    chk("abort outputs", 64'({valid_out, wb_en_out, type_out, rd_out,
        result_out}), 64'({1'b0, 1'b0, 3'd7, 5'd0, 32'd0}));
    base_op("abort add", 3'd0, 7'd0, 3'd0, 32'd10, 32'd20, 5'd4);
    drive(3'd7, 7'd0, 3'd0, 32'd0, 32'd0, 5'd0);
    vc = 0;
    repeat (40) begin
      step();
      if (valid_out) vc++;
    end
    chk("abort no result", 64'(vc), 64'd0);

    for (int i = 0; i < 12; i++) begin
      logic [2:0] f3;
      logic [31:0] a, b;
      f3 = 3'($urandom_range(0, 7));
      a = pick(); b = pick();
      run_m($sformatf("rnd m%0d f3=%0d a=%h b=%h", i, f3, a, b),
            f3, a, b, 5'($urandom), ref_m(f3, a, b),
            1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 30; i++) begin
      logic [2:0] t, f3;
      logic [6:0] f7;
      t = 3'($urandom_range(0, 6));
      f3 = 3'($urandom_range(0, 7));
      f7 = ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'd0;
      base_op($sformatf("rnd base%0d t=%0d f3=%0d", i, t, f3),
              t, f7, f3, pick(), pick(), 5'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
